// File: rtl/als_spi_if.sv
// ---------------------------------------------------------------------------
// als_spi_if
// Bundle of the signals between the ambient-light SPI responder and the
// outside world. clk and rst are not part of the bundle and stay plain ports.
//
//   ncs          chip select from SPI master, active low, async to clk
//   sck          SPI clock from master, idle high, async to clk
//   sdo          serial data to master, MSB first
//   sample_data  next light sample
//   sample_valid sample_data valid
//   sample_ready holding register can accept a sample
//   frame_done   one-cycle pulse when a full 16-bit frame has been sent
//   underrun     one-cycle pulse when a frame starts with no fresh sample
//   abort_cnt    saturating count of frames cut short by ncs
//
// Modports: master = SPI master / sample producer side, slave = responder.
// ---------------------------------------------------------------------------
interface als_spi_if;
    logic       ncs;
    logic       sck;
    logic       sdo;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       frame_done;
    logic       underrun;
    logic [7:0] abort_cnt;

    modport master (
        output ncs, sck, sample_data, sample_valid,
        input  sdo, sample_ready, frame_done, underrun, abort_cnt
    );

    modport slave (
        input  ncs, sck, sample_data, sample_valid,
        output sdo, sample_ready, frame_done, underrun, abort_cnt
    );
endinterface

// File: rtl/als_spi_responder.sv
// ---------------------------------------------------------------------------
// als_spi_responder
// SPI slave that answers every chip-select frame with a 16-bit word
// {4'b0000, sample[7:0], 4'b0000}, bit 15 first. ncs and sck are sampled
// with clk through SYNC_STAGES flops; sdo changes SYNC_STAGES+1 clk cycles
// after an sck falling edge on the pin, so the master must keep each sck
// half-period at least SYNC_STAGES+3 clk cycles long.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on ncs/sck, legal 2..4 (default 2)
//   IDLE_SDO     sdo level outside a frame (default 1'b0)
//
// Ports
//   clk          system clock, all state on posedge
//   rst          asynchronous active-high reset
//   bus          als_spi_if.slave (ncs, sck, sdo, sample handshake, status)
//
// Build option
//   ALS_SPI_RESPONDER_LFSR_EN  when defined, frame payloads come from an
//   internal 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'h01) advanced once
//   per frame; the sample port is ignored and sample_ready is held at 0.
// ---------------------------------------------------------------------------
module als_spi_responder #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_SDO    = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    als_spi_if.slave bus
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        HOLD      = 2'd3
    } state_t;

    // After reset the synchronizer holds its reset value (all ones), not the
    // pin. WAIT_IDLE must not trust "ncs high" until the chain has refilled
    // from the pin, otherwise a master holding ncs low through reset would
    // look like a fresh falling edge.
    localparam logic [2:0] FLUSH_CYC = 3'(SYNC_STAGES);

    state_t                 state_r;
    state_t                 state_next_s;

    logic [SYNC_STAGES-1:0] ncs_sync_r;
    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic                   ncs_prev_r;
    logic                   sck_prev_r;
    logic [2:0]             flush_cnt_r;

    logic                   ncs_s;
    logic                   sck_s;
    logic                   ncs_fall_s;
    logic                   ncs_rise_s;
    logic                   sck_fall_s;
    logic                   flush_done_s;

    logic [15:0]            shift_r;
    logic [15:0]            shift_next_s;
    logic [4:0]             bit_cnt_r;

    logic                   load_s;
    logic                   shift_en_s;
    logic                   done_s;
    logic                   abort_s;
    logic                   sdo_next_s;

    logic [7:0]             payload_s;
    logic [15:0]            frame_s;
    logic                   ready_s;
    logic                   underrun_next_s;

    logic                   sdo_r;
    logic                   frame_done_r;
    logic                   underrun_r;
    logic [7:0]             abort_cnt_r;

    // ---------------------------------------------------------------------
    // Synchronizers and edge detection
    // ---------------------------------------------------------------------

    // Synchronizer chains plus one extra flop each for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_sync_r <= {SYNC_STAGES{1'b1}};
            sck_sync_r <= {SYNC_STAGES{1'b1}};
            ncs_prev_r <= 1'b1;
            sck_prev_r <= 1'b1;
        end else begin
            ncs_sync_r <= {ncs_sync_r[SYNC_STAGES-2:0], bus.ncs};
            sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], bus.sck};
            ncs_prev_r <= ncs_sync_r[SYNC_STAGES-1];
            sck_prev_r <= sck_sync_r[SYNC_STAGES-1];
        end
    end

    // Counts clocks since reset until the synchronizer reflects the pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_r <= 3'd0;
        end else if (!flush_done_s) begin
            flush_cnt_r <= flush_cnt_r + 3'd1;
        end
    end

    assign ncs_s        = ncs_sync_r[SYNC_STAGES-1];
    assign sck_s        = sck_sync_r[SYNC_STAGES-1];
    assign ncs_fall_s   = ncs_prev_r & ~ncs_s;
    assign ncs_rise_s   = ~ncs_prev_r & ncs_s;
    assign sck_fall_s   = sck_prev_r & ~sck_s;
    assign flush_done_s = (flush_cnt_r == FLUSH_CYC);

    // ---------------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------------

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= WAIT_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode; an ncs rise outranks a coincident sck fall
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            WAIT_IDLE: begin
                if (flush_done_s && ncs_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_IDLE;
                end
            end
            IDLE: begin
                if (ncs_fall_s) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (ncs_rise_s) begin
                    state_next_s = IDLE;
                end else if (sck_fall_s && (bit_cnt_r == 5'd15)) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            HOLD: begin
                if (ncs_rise_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = WAIT_IDLE;
            end
        endcase
    end

    // FSM output decode: datapath strobes and next sdo level.
    // An sck fall coinciding with the ncs fall arrives while still in IDLE,
    // so it never shifts.
    always_comb begin
        load_s     = 1'b0;
        shift_en_s = 1'b0;
        done_s     = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            WAIT_IDLE: begin
                load_s = 1'b0;
            end
            IDLE: begin
                load_s = ncs_fall_s;
            end
            SHIFT: begin
                abort_s    = ncs_rise_s;
                shift_en_s = sck_fall_s & ~ncs_rise_s;
                done_s     = sck_fall_s & ~ncs_rise_s & (bit_cnt_r == 5'd15);
            end
            HOLD: begin
                shift_en_s = sck_fall_s & ~ncs_rise_s;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase

        if ((state_next_s == SHIFT) || (state_next_s == HOLD)) begin
            sdo_next_s = shift_next_s[15];
        end else begin
            sdo_next_s = IDLE_SDO;
        end
    end

    // ---------------------------------------------------------------------
    // Shift register and bit counter
    // ---------------------------------------------------------------------

    assign frame_s = {4'b0000, payload_s, 4'b0000};

    // Next shift register value: load on frame start, else zero-fill shift
    always_comb begin
        if (load_s) begin
            shift_next_s = frame_s;
        end else if (shift_en_s) begin
            shift_next_s = {shift_r[14:0], 1'b0};
        end else begin
            shift_next_s = shift_r;
        end
    end

    // Shift register and bit counter (counter only advances inside SHIFT)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r   <= 16'h0000;
            bit_cnt_r <= 5'd0;
        end else begin
            shift_r <= shift_next_s;
            if (load_s) begin
                bit_cnt_r <= 5'd0;
            end else if (shift_en_s && (state_r == SHIFT)) begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Payload source
    // ---------------------------------------------------------------------
`ifdef ALS_SPI_RESPONDER_LFSR_EN
    logic [7:0] lfsr_r;

    // Fibonacci LFSR, taps 8,6,5,4; the current value is sent, then advanced
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= 8'h01;
        end else if (load_s) begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end

    assign payload_s       = lfsr_r;
    assign ready_s         = 1'b0;
    assign underrun_next_s = 1'b0;
`else
    logic       full_r;
    logic [7:0] hold_r;
    logic [7:0] last_r;
    logic       accept_s;

    // A frame load frees the holding register in the same cycle, so a
    // producer can refill it on the very cycle the old sample is consumed.
    assign ready_s         = ~full_r | load_s;
    assign accept_s        = bus.sample_valid & ready_s;
    assign payload_s       = full_r ? hold_r : last_r;
    assign underrun_next_s = load_s & ~full_r;

    // Holding register and the copy of the last sample actually consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r <= 1'b0;
            hold_r <= 8'h00;
            last_r <= 8'h00;
        end else begin
            if (load_s && full_r) begin
                last_r <= hold_r;
            end
            if (accept_s) begin
                hold_r <= bus.sample_data;
                full_r <= 1'b1;
            end else if (load_s) begin
                full_r <= 1'b0;
            end
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Registered outputs
    // ---------------------------------------------------------------------

    // Output registers; sdo is registered from its next value so the pin
    // latency stays at SYNC_STAGES+1 clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdo_r        <= IDLE_SDO;
            frame_done_r <= 1'b0;
            underrun_r   <= 1'b0;
            abort_cnt_r  <= 8'h00;
        end else begin
            sdo_r        <= sdo_next_s;
            frame_done_r <= done_s;
            underrun_r   <= underrun_next_s;
            if (abort_s && (abort_cnt_r != 8'hFF)) begin
                abort_cnt_r <= abort_cnt_r + 8'd1;
            end
        end
    end

    assign bus.sdo          = sdo_r;
    assign bus.frame_done   = frame_done_r;
    assign bus.underrun     = underrun_r;
    assign bus.abort_cnt    = abort_cnt_r;
    assign bus.sample_ready = ready_s;

endmodule

// File: tb/tb_als_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_als_spi_responder
// Drives SPI frames and samples into als_spi_responder. Expected sdo bits,
// frame_done and underrun events are queued by the stimulus from a
// frame-level model; independent monitors pop and compare when the DUT
// presents them.
// ---------------------------------------------------------------------------
module tb_als_spi_responder;

    localparam int   SS       = 2;
    localparam logic IDLE_SDO = 1'b0;
    localparam int   H        = 8;     // sck half-period in clk cycles

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    als_spi_if bus();

    als_spi_responder #(.SYNC_STAGES(SS), .IDLE_SDO(IDLE_SDO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard queues
    bit exp_sdo_q[$];
    int exp_done_q[$];
    int exp_und_q[$];
    int done_id = 0;
    int und_id  = 0;
    int done_seen = 0;
    int und_seen  = 0;

    // Frame-level reference model
    bit         m_full;
    logic [7:0] m_hold;
    logic [7:0] m_last;
    logic [7:0] m_lfsr;
    int         m_abort;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic void flag_fail(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event seen, none expected", name);
    endfunction

    function automatic void model_reset();
        m_full  = 1'b0;
        m_hold  = 8'h00;
        m_last  = 8'h00;
        m_lfsr  = 8'h01;
        m_abort = 0;
    endfunction

    function automatic bit exp_ready();
`ifdef ALS_SPI_RESPONDER_LFSR_EN
        return 1'b0;
`else
        return !m_full;
`endif
    endfunction

    // Decides the payload of a frame that is about to start
    function automatic logic [7:0] model_frame_start();
        logic [7:0] p;
`ifdef ALS_SPI_RESPONDER_LFSR_EN
        p      = m_lfsr;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`else
        if (m_full) begin
            p      = m_hold;
            m_last = m_hold;
            m_full = 1'b0;
        end else begin
            p = m_last;
            exp_und_q.push_back(und_id);
            und_id++;
        end
`endif
        return p;
    endfunction

    // Monitor: master samples sdo just before each sck fall while selected
    always @(negedge bus.sck) begin
        if (bus.ncs == 1'b0) begin
            if (exp_sdo_q.size() == 0) begin
                flag_fail("sdo_sample");
            end else begin
                check("sdo_bit", {31'd0, bus.sdo}, {31'd0, exp_sdo_q.pop_front()});
            end
        end
    end

    // Monitor: frame_done and underrun pulses
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                flag_fail("frame_done");
            end else begin
                check("frame_done_order", done_seen, exp_done_q.pop_front());
                done_seen++;
            end
        end
        if (bus.underrun === 1'b1) begin
            if (exp_und_q.size() == 0) begin
                flag_fail("underrun");
            end else begin
                check("underrun_order", und_seen, exp_und_q.pop_front());
                und_seen++;
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer_sample(input logic [7:0] d);
        bit rdy;
        rdy              = exp_ready();
        bus.sample_data  = d;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        check("sample_ready", {31'd0, bus.sample_ready}, {31'd0, rdy});
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        if (rdy) begin
            m_full = 1'b1;
            m_hold = d;
        end
    endtask

    task automatic post_frame_checks();
        check("abort_cnt", {24'd0, bus.abort_cnt}, m_abort);
        check("sdo_idle", {31'd0, bus.sdo}, {31'd0, IDLE_SDO});
        check("frame_done_pending", exp_done_q.size(), 0);
        check("underrun_pending", exp_und_q.size(), 0);
        check("sdo_bits_pending", exp_sdo_q.size(), 0);
    endtask

    // One chip-select frame with nfalls sck falling edges
    task automatic run_frame(input int nfalls);
        logic [7:0]  p;
        logic [15:0] fr;
        p  = model_frame_start();
        fr = {4'b0000, p, 4'b0000};
        bus.ncs = 1'b0;
        clks(H);
        for (int i = 0; i < nfalls; i++) begin
            exp_sdo_q.push_back((i < 16) ? fr[15-i] : 1'b0);
            if (i == 15) begin
                exp_done_q.push_back(done_id);
                done_id++;
            end
            bus.sck = 1'b0;
            clks(H);
            bus.sck = 1'b1;
            clks(H);
        end
        if (nfalls < 16 && m_abort < 255) m_abort++;
        bus.ncs = 1'b1;
        clks(12);
        post_frame_checks();
    endtask

    // Reset pulse after five falls with ncs held low, then stray falls
    task automatic reset_mid_frame();
        logic [7:0]  p;
        logic [15:0] fr;
        p  = model_frame_start();
        fr = {4'b0000, p, 4'b0000};
        bus.ncs = 1'b0;
        clks(H);
        for (int i = 0; i < 5; i++) begin
            exp_sdo_q.push_back(fr[15-i]);
            bus.sck = 1'b0;
            clks(H);
            bus.sck = 1'b1;
            clks(H);
        end
        rst = 1'b1;
        clks(2);
        rst = 1'b0;
        model_reset();
        clks(6);
        for (int i = 0; i < 3; i++) begin
            exp_sdo_q.push_back(IDLE_SDO);
            bus.sck = 1'b0;
            clks(H);
            bus.sck = 1'b1;
            clks(H);
        end
        post_frame_checks();
        bus.ncs = 1'b1;
        clks(12);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf;
        rst              = 1'b1;
        bus.ncs          = 1'b1;
        bus.sck          = 1'b1;
        bus.sample_data  = 8'h00;
        bus.sample_valid = 1'b0;
        model_reset();
        clks(3);
        check("rst_sdo", {31'd0, bus.sdo}, {31'd0, IDLE_SDO});
        check("rst_sample_ready", {31'd0, bus.sample_ready}, {31'd0, exp_ready()});
        check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        check("rst_underrun", {31'd0, bus.underrun}, 32'd0);
        check("rst_abort_cnt", {24'd0, bus.abort_cnt}, 32'd0);
        rst = 1'b0;
        clks(8);
        check("post_rst_sdo", {31'd0, bus.sdo}, {31'd0, IDLE_SDO});
        check("post_rst_sample_ready", {31'd0, bus.sample_ready}, {31'd0, exp_ready()});

        // Basic frame of 8'hA5
        offer_sample(8'hA5);
        run_frame(16);
        // Underrun: last consumed sample 8'h3C, holding empty
        offer_sample(8'h3C);
        run_frame(16);
        run_frame(16);
        // Abort after 7 falls, then a normal frame
        offer_sample(8'h5A);
        run_frame(7);
        offer_sample(8'hC3);
        run_frame(16);
        // Extra falls past the 16th shift zeros
        offer_sample(8'hFF);
        run_frame(20);
        // Reset mid-frame, then a fresh frame needs ncs high then low
        offer_sample(8'h77);
        reset_mid_frame();
        offer_sample(8'h96);
        run_frame(16);
        // Offer while full is refused; first sample is sent
        offer_sample(8'h11);
        offer_sample(8'h22);
        run_frame(16);

        // Randomized frames
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 3) != 0) offer_sample(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 4) == 0) offer_sample(8'($urandom_range(0, 255)));
            case ($urandom_range(0, 6))
                0:       nf = $urandom_range(0, 15);
                1:       nf = $urandom_range(17, 20);
                default: nf = 16;
            endcase
            run_frame(nf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
